// File: rtl/imm_gen_if.sv
// imm_gen_if: valid/ready request and response bundle of the immediate generator stage
interface imm_gen_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      in_instr;
    logic [2:0]       in_immsrc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_instr, in_immsrc, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_instr, in_immsrc, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );
endinterface

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: pipelined immediate generator with 2-entry skid buffer and illegal-format counter
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             err_count_clr,
    output logic [CNT_W-1:0] err_count,
    imm_gen_if.slave         bus
);
    typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, FULL = 2'b11} state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [XLEN-1:0]  head_imm_q, head_imm_d, skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] head_tag_q, head_tag_d, skid_tag_q, skid_tag_d;
    logic             head_err_q, head_err_d, skid_err_q, skid_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [24:0]      f;
    logic [2:0]       src;
    logic [XLEN-1:0]  new_imm;
    logic             new_err;
    logic             acc, pop;

    assign f   = bus.in_instr;
    assign src = bus.in_immsrc;

    // decode the immediate of the incoming instruction
    always_comb begin
        new_err = src == 3'd7;
        new_imm = src == 3'd0 ? XLEN'($signed(f[24:13])) :
                  src == 3'd1 ? XLEN'($signed({f[24:18], f[4:0]})) :
                  src == 3'd2 ? XLEN'($signed({f[24:5], 12'b0})) :
                  src == 3'd3 ? XLEN'(f[12:8]) :
                  src == 3'd4 ? (XLEN == 64 ? XLEN'(f[18:13]) : XLEN'(f[17:13])) :
                  src == 3'd5 ? XLEN'($signed({f[24], f[0], f[23:18], f[4:1], 1'b0})) :
                  src == 3'd6 ? XLEN'($signed({f[24], f[12:5], f[13], f[23:14], 1'b0})) :
                  '0;
    end

    // handshake events; a flushed input is never accepted
    always_comb begin
        acc = bus.in_valid & in_ready_q & ~flush;
        pop = state_q[1] & bus.out_ready;
    end

    // next occupancy of the two-entry buffer
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   state_d = acc ? ONE : EMPTY;
            ONE:     state_d = acc & ~pop ? FULL : (~acc & pop ? EMPTY : ONE);
            FULL:    state_d = pop ? ONE : FULL;
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
        in_ready_d = state_d != FULL;
    end

    // move entries: new data lands in the head when it frees up, otherwise in the skid
    always_comb begin
        head_imm_d = head_imm_q;
        head_tag_d = head_tag_q;
        head_err_d = head_err_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        skid_err_d = skid_err_q;
        if (state_q == FULL && pop) begin
            head_imm_d = skid_imm_q;
            head_tag_d = skid_tag_q;
            head_err_d = skid_err_q;
        end else if (acc && (state_q == EMPTY || pop)) begin
            head_imm_d = new_imm;
            head_tag_d = bus.in_tag;
            head_err_d = new_err;
        end else if (acc) begin
            skid_imm_d = new_imm;
            skid_tag_d = bus.in_tag;
            skid_err_d = new_err;
        end
    end

    // saturating illegal-format counter, clear wins over increment
    always_comb begin
        err_count_d = err_count_clr ? '0 :
                      acc & new_err & ~&err_count_q ? err_count_q + 1'b1 : err_count_q;
    end

    // state and data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            head_imm_q  <= '0;
            head_tag_q  <= '0;
            head_err_q  <= 1'b0;
            skid_imm_q  <= '0;
            skid_tag_q  <= '0;
            skid_err_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            head_imm_q  <= head_imm_d;
            head_tag_q  <= head_tag_d;
            head_err_q  <= head_err_d;
            skid_imm_q  <= skid_imm_d;
            skid_tag_q  <= skid_tag_d;
            skid_err_q  <= skid_err_d;
            err_count_q <= err_count_d;
        end
    end

    // drive outputs from the head register
    always_comb begin
        bus.in_ready  = in_ready_q;
        bus.out_valid = state_q[1];
        bus.out_imm   = head_imm_q;
        bus.out_tag   = head_tag_q;
        bus.out_err   = head_err_q;
        err_count     = err_count_q;
    end
endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Pipelined, parametrised immediate generator for the decode stage of the pipelined core. It extends the single-cycle immediate decoder with configurable XLEN (32/64), two extra formats (CSR zimm, shift amount), and a valid/ready handshake with a 2-entry skid buffer. Illegal-format requests are flagged per transaction and counted in a saturating counter. It sits between the instruction-fetch register and the execute operand mux.

## Interface
- XLEN, 32, output immediate width; legal values are 32 and 64 only.
- TAG_W, 5, width of the sideband tag carried alongside each transaction, e.g. the destination register.
- CNT_W, 8, width of the illegal-format counter.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all buffered transactions.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  stage can accept a transaction; registered.
- in_instr  in  25  instruction bits [31:7]; field[i] = instr[i+7].
- in_immsrc  in  3  format select.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  generated immediate.
- out_tag  out  TAG_W  tag of the output transaction.
- out_err  out  1  output transaction used an illegal immsrc.
- err_count  out  CNT_W  saturating count of accepted illegal transactions.
- err_count_clr  in  1  synchronous clear of err_count.

## Operation
- Formats by immsrc, with f = in_instr:
  - 0, I: sext({f[24:13]}).
  - 1, S: sext({f[24:18], f[4:0]}).
  - 2, U: {f[24:5], 12'b0}; for XLEN=64, bit 31 is sign-extended.
  - 3, Z (CSR zimm): zext(f[12:8]).
  - 4, SH: zext(f[17:13]) when XLEN=32; zext(f[18:13]) when XLEN=64.
  - 5, B: sext({f[24], f[0], f[23:18], f[4:1], 1'b0}).
  - 6, J: sext({f[24], f[12:5], f[13], f[23:14], 1'b0}).
  - 7: illegal; imm = 0 and err = 1.
- All sign extension is to XLEN bits.
- Accept condition: in_valid & in_ready & ~flush.
- Immediate is computed combinationally at accept time and stored with its tag and err bit.
- Storage has two entries:
  - The output register is the head.
  - The skid register holds one extra transaction.
- FIFO order is strict; no transaction is dropped or duplicated except by flush.
- State is derived from {out_valid, skid_valid}: EMPTY (0,0), ONE (1,0), FULL (1,1). The state (0,1) is unreachable.
- Transitions:
  - EMPTY: accept -> ONE.
  - ONE, accept and pop -> ONE (new data in head).
  - ONE, accept and no pop -> FULL.
  - ONE, pop only -> EMPTY.
  - FULL, pop -> ONE (skid moves to head). No accept is possible in FULL.
- Pop condition: out_valid & out_ready.
- in_ready (registered) = next state != FULL.
- flush:
  - Next state is EMPTY and in_ready = 1.
  - An input presented in the same cycle is discarded and not counted.
  - err_count is unaffected.
- err_count:
  - Increments on each accepted transaction with immsrc = 7.
  - Saturates at 2^CNT_W-1.
  - err_count_clr has priority over increment in the same cycle; the count becomes 0.

## Timing
- Reset values (asynchronous): out_valid=0, out_imm=0, out_tag=0, out_err=0, skid empty, in_ready=1, err_count=0.
- Latency: accept at edge N makes the transaction visible on out_* after edge N, i.e. 1 cycle.
- Throughput is 1 transaction/cycle while out_ready=1.
- While out_valid & ~out_ready, out_imm, out_tag and out_err are held stable.
- in_ready falls one cycle after the skid fills.
- in_ready rises in the cycle after the pop that empties the skid.
- Simultaneous accept and pop in ONE: no bubble, no stall.
- rst_n asserted mid-transfer: all buffered transactions are lost immediately (asynchronous). The first accept is possible on the first edge after deassertion.

## Test plan
- I-type, XLEN=32: instr 0xFFF00093 (f=0x1FFE001), immsrc=0, out_ready=1 -> one cycle later out_valid=1, out_imm=0xFFFFFFFF, out_err=0.
- B-type: instr 0xFE000EE3, immsrc=5 -> out_imm=0xFFFFFFFC.
- J-type: instr 0x0080006F, immsrc=6 -> out_imm=0x00000008.
- XLEN=64 U-type: instr 0x800000B7, immsrc=2 -> out_imm=0xFFFFFFFF80000000.
- XLEN=64 SH: instr 0x03F0D093, immsrc=4 -> out_imm=0x3F.
- Backpressure: send tags 1,2,3 back-to-back with out_ready=0.
  - Head = tag 1, skid = tag 2.
  - in_ready=0 from the 3rd cycle; tag 3 is not accepted.
  - Raise out_ready -> tags 1,2,3 emerge in order with no loss.
- Illegal/counter, CNT_W=2: send 4 transactions with immsrc=7.
  - Each output has out_imm=0, out_err=1.
  - err_count sequence is 1,2,3,3.
  - Assert err_count_clr together with a 5th illegal transaction -> err_count=0.
- Flush/reset:
  - In FULL, pulse flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed input never appears.
  - Assert rst_n=0 mid-stream -> all outputs take reset values immediately.
